layer_sequencer: RTL

Frame-level controller for one fully connected layer of `neuron` instances. It collects an input vector from the upstream stream into a local buffer, then drives the shared `freeze` and input bus so that every neuron in the layer accumulates over exactly `NUM_INPUTS` consecutive cycles. It then captures all neuron outputs in one cycle and serialises them to the next layer over a valid/ready stream. It sits between the previous layer (or the pixel source) and the next layer, one instance per layer.

---
 rtl/layer_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/layer_sequencer.sv
// layer_sequencer: load/run/capture/drain frame controller for one neuron layer; optional argmax via LAYER_SEQ_ARGMAX_EN
module layer_sequencer #(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16,
  localparam int IW = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1,
  localparam int NW = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              in_ready,
  output logic                              freeze,
  output logic [DATA_WIDTH-1:0]             neuron_in,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
  output logic                              out_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_last,
  input  logic                              out_ready,
  output logic                              busy
`ifdef LAYER_SEQ_ARGMAX_EN
  ,
  output logic [NW-1:0]                     class_idx,
  output logic                              class_valid
`endif
);
  typedef enum logic [1:0] {LOAD, RUN, CAPT, DRAIN} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NW-1:0] rd_q, rd_d;
  logic freeze_q, freeze_d;
  logic [DATA_WIDTH-1:0] nin_q, nin_d;
  logic [DATA_WIDTH-1:0] ibuf_q [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] cap_q [NUM_NEURONS];
  logic in_hs, out_hs, last_in, last_out;
  assign in_ready  = state_q == LOAD;
  assign busy      = state_q != LOAD;
  assign out_valid = state_q == DRAIN;
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign last_in   = idx_q == IW'(NUM_INPUTS - 1);
  assign last_out  = rd_q == NW'(NUM_NEURONS - 1);
  assign out_data  = out_valid ? cap_q[rd_q] : '0;
  assign out_last  = out_valid & last_out;
  assign freeze    = freeze_q;
  assign neuron_in = nin_q;
  // next state: idx_q is the write index in LOAD and the run cycle c in RUN; freeze is registered from the next state
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rd_d     = rd_q;
    nin_d    = nin_q;
    unique case (state_q)
      LOAD: if (in_hs) begin
        idx_d   = last_in ? '0 : idx_q + 1'b1;
        state_d = last_in ? RUN : LOAD;
        nin_d   = last_in ? (idx_q == '0 ? in_data : ibuf_q[0]) : nin_q;
      end
      RUN: begin
        idx_d   = last_in ? '0 : idx_q + 1'b1;
        state_d = last_in ? CAPT : RUN;
        nin_d   = last_in ? nin_q : ibuf_q[idx_q + 1'b1];
      end
      CAPT: begin
        state_d = DRAIN;
        rd_d    = '0;
      end
      DRAIN: if (out_hs) begin
        rd_d    = last_out ? '0 : rd_q + 1'b1;
        state_d = last_out ? LOAD : DRAIN;
      end
      default: state_d = LOAD;
    endcase
    freeze_d = state_d != RUN;
  end
  // control registers with synchronous reset back to an empty LOAD
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      idx_q    <= '0;
      rd_q     <= '0;
      freeze_q <= 1'b1;
      nin_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rd_q     <= rd_d;
      freeze_q <= freeze_d;
      nin_q    <= nin_d;
    end
  end
  // data storage needs no reset: every entry is written before it is read
  always_ff @(posedge clk) begin
    if (in_hs) ibuf_q[idx_q] <= in_data;
    if (state_q == CAPT)
      for (int k = 0; k < NUM_NEURONS; k++) cap_q[k] <= neuron_out[k*DATA_WIDTH +: DATA_WIDTH];
  end
`ifdef LAYER_SEQ_ARGMAX_EN
  logic [DATA_WIDTH-1:0] best_q;
  logic [NW-1:0] bidx_q, cand_idx;
  logic better;
  assign better      = rd_q == '0 || $signed(cap_q[rd_q]) > $signed(best_q);
  assign cand_idx    = better ? rd_q : bidx_q;
  assign class_valid = out_hs & last_out;
  assign class_idx   = class_valid ? cand_idx : bidx_q;
  // running signed maximum over drained words; strict compare keeps the lowest index on ties
  always_ff @(posedge clk) begin
    if (rst) begin
      best_q <= '0;
      bidx_q <= '0;
    end else if (out_hs) begin
      best_q <= better ? cap_q[rd_q] : best_q;
      bidx_q <= cand_idx;
    end
  end
`endif
endmodule
